// File: rtl/agu_issue_arbiter_if.sv
// Bundles requester, FU and downstream LSQ handshake signals for the AGU issue arbiter.
// master = arbiter side, slave = surrounding requesters/FU/consumer.
interface agu_issue_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int XLEN    = 32,
   parameter int TAG_W   = 6
);
   localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*XLEN-1:0]  req_rs1;
   logic [NUM_REQ*XLEN-1:0]  req_rs2;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic [NUM_REQ-1:0]       req_grant;

   logic                     fu_rd_in;
   logic                     fu_stall;
   logic [XLEN-1:0]          fu_rs1;
   logic [XLEN-1:0]          fu_rs2;
   logic                     fu_data_ready;
   logic [XLEN-1:0]          fu_result;

   logic                     out_valid;
   logic [XLEN-1:0]          out_addr;
   logic [TAG_W-1:0]         out_tag;
   logic [SRC_W-1:0]         out_src;
   logic                     out_ready;

   modport master (
      input  req_valid, req_rs1, req_rs2, req_tag, fu_data_ready, fu_result, out_ready,
      output req_grant, fu_rd_in, fu_stall, fu_rs1, fu_rs2, out_valid, out_addr, out_tag, out_src
   );

   modport slave (
      output req_valid, req_rs1, req_rs2, req_tag, fu_data_ready, fu_result, out_ready,
      input  req_grant, fu_rd_in, fu_stall, fu_rs1, fu_rs2, out_valid, out_addr, out_tag, out_src
   );
endinterface

// File: rtl/agu_issue_arbiter.sv
// Round-robin issue of NUM_REQ load/store requests onto one single-cycle AGU; grant is
// combinational, address appears one cycle later and is held while the LSQ applies backpressure.
module agu_issue_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int XLEN    = 32,
   parameter int TAG_W   = 6
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                squash,
   agu_issue_arbiter_if.master bus
);
   localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [SRC_W-1:0] rr_ptr;
   logic [SRC_W-1:0] sel;
   logic [SRC_W-1:0] idx;
   logic             found;
   logic             take;
   logic             stall;
   logic             grant_en;
   logic             out_vld;
   logic             pipe_valid;
   logic [TAG_W-1:0] pipe_tag;
   logic [SRC_W-1:0] pipe_src;
   logic [NUM_REQ-1:0] grant;

   assign out_vld  = bus.fu_data_ready & pipe_valid;
   assign stall    = out_vld & ~bus.out_ready & ~squash;
   assign grant_en = ~stall & ~squash & ~reset;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign take = found & grant_en;

   always_comb begin
      grant = '0;
      if (take) grant[sel] = 1'b1;
   end

   assign bus.req_grant = grant;
   assign bus.fu_rd_in  = take;
   assign bus.fu_stall  = stall;
   assign bus.fu_rs1    = take ? bus.req_rs1[sel*XLEN +: XLEN] : '0;
   assign bus.fu_rs2    = take ? bus.req_rs2[sel*XLEN +: XLEN] : '0;

   assign bus.out_valid = out_vld;
   assign bus.out_addr  = bus.fu_result;
   assign bus.out_tag   = pipe_tag;
   assign bus.out_src   = pipe_src;

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr     <= '0;
         pipe_valid <= 1'b0;
         pipe_tag   <= '0;
         pipe_src   <= '0;
      end else begin
         if (take)
            rr_ptr <= (sel == SRC_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

         // Tag/src shadow the FU output register; squash wins over the stall hold.
         if (squash) begin
            pipe_valid <= 1'b0;
         end else if (stall) begin
            pipe_valid <= pipe_valid;
         end else if (take) begin
            pipe_valid <= 1'b1;
            pipe_tag   <= bus.req_tag[sel*TAG_W +: TAG_W];
            pipe_src   <= sel;
         end else begin
            pipe_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_agu_issue_arbiter.sv
// Randomised and directed bench for agu_issue_arbiter with a transaction-level reference model
// and a scoreboard queue drained by an independent output monitor.
module tb_agu_issue_arbiter;
   localparam int N = 4;
   localparam int XW = 32;
   localparam int TW = 6;

   typedef struct {
      logic [XW-1:0] addr;
      logic [TW-1:0] tag;
      logic [1:0]    src;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic squash = 1'b0;
   logic force_dr = 1'b0;
   logic fu_dr_reg;
   logic [XW-1:0] fu_res_reg;

   agu_issue_arbiter_if #(.NUM_REQ(N), .XLEN(XW), .TAG_W(TW)) bus_i ();

   agu_issue_arbiter #(.NUM_REQ(N), .XLEN(XW), .TAG_W(TW)) dut (
      .clock (clock),
      .reset (reset),
      .squash(squash),
      .bus   (bus_i)
   );

   always #5 clock = ~clock;

   // Single-cycle adder FU with a holdable output register.
   always @(posedge clock) begin
      if (reset) begin
         fu_dr_reg  <= 1'b0;
         fu_res_reg <= '0;
      end else if (!bus_i.fu_stall) begin
         fu_dr_reg <= bus_i.fu_rd_in;
         if (bus_i.fu_rd_in) fu_res_reg <= bus_i.fu_rs1 + bus_i.fu_rs2;
      end
   end
   assign bus_i.fu_data_ready = fu_dr_reg | force_dr;
   assign bus_i.fu_result     = fu_res_reg;

   int   n_cmp = 0;
   int   n_err = 0;
   bit   chk_on = 1'b0;
   exp_t q[$];

   // Requester-side state: a request stays up with fixed operands until granted.
   bit            req_on [N];
   logic [XW-1:0] r1 [N];
   logic [XW-1:0] r2 [N];
   logic [TW-1:0] tg [N];

   int model_ptr = 0;
   bit model_pending = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [XW-1:0] a, input logic [XW-1:0] b, input logic [TW-1:0] t);
      req_on[i] = 1'b1;
      r1[i] = a;
      r2[i] = b;
      tg[i] = t;
   endtask

   task automatic cycle(input bit rdy, input bit sq, input bit rst, input bit frc);
      bit stall;
      int g;
      logic [N-1:0] exp_grant;
      exp_t e;
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
         bus_i.req_valid[i]           = req_on[i];
         bus_i.req_rs1[i*XW +: XW]    = r1[i];
         bus_i.req_rs2[i*XW +: XW]    = r2[i];
         bus_i.req_tag[i*TW +: TW]    = tg[i];
      end
      bus_i.out_ready = rdy;
      squash   = sq;
      reset    = rst;
      force_dr = frc;
      #1;
      stall = model_pending && !rdy && !sq;
      g = -1;
      if (!stall && !sq && !rst)
         for (int k = 0; k < N; k++)
            if (g < 0 && req_on[(model_ptr + k) % N]) g = (model_ptr + k) % N;
      exp_grant = (g >= 0) ? N'(1) << g : '0;
      if (chk_on) begin
         chk("req_grant", 64'(bus_i.req_grant), 64'(exp_grant));
         chk("fu_rd_in",  64'(bus_i.fu_rd_in),  64'(g >= 0));
         chk("fu_stall",  64'(bus_i.fu_stall),  64'(stall));
         chk("out_valid", 64'(bus_i.out_valid), 64'(model_pending));
         chk("fu_rs1",    64'(bus_i.fu_rs1),    (g >= 0) ? 64'(r1[g]) : 64'd0);
         chk("fu_rs2",    64'(bus_i.fu_rs2),    (g >= 0) ? 64'(r2[g]) : 64'd0);
      end
      if (rst) begin
         model_ptr = 0;
         model_pending = 1'b0;
         q.delete();
      end else if (sq) begin
         model_pending = 1'b0;
         q.delete();
      end else if (!stall) begin
         model_pending = (g >= 0);
         if (g >= 0) begin
            e.addr = r1[g] + r2[g];
            e.tag  = tg[g];
            e.src  = 2'(g);
            q.push_back(e);
            model_ptr = (g + 1) % N;
            req_on[g] = 1'b0;
         end
      end
   endtask

   // Monitor: every accepted address must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #3;
         if (chk_on && !reset && !squash && bus_i.out_valid && bus_i.out_ready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL pop_empty @%0t: got out_valid=1 expected no outstanding op", $time);
            end else begin
               e = q.pop_front();
               chk("out_addr", 64'(bus_i.out_addr), 64'(e.addr));
               chk("out_tag",  64'(bus_i.out_tag),  64'(e.tag));
               chk("out_src",  64'(bus_i.out_src),  64'(e.src));
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         req_on[i] = 1'b0; r1[i] = '0; r2[i] = '0; tg[i] = '0;
      end
      bus_i.req_valid = '0;
      bus_i.req_rs1   = '0;
      bus_i.req_rs2   = '0;
      bus_i.req_tag   = '0;
      bus_i.out_ready = 1'b1;

      cycle(1, 0, 1, 0);
      chk_on = 1'b1;
      cycle(1, 0, 1, 0);
      cycle(1, 0, 0, 0);

      // Single request from requester 1.
      set_req(1, 32'h1000, 32'h24, 6'd5);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      chk("single_addr", 64'(bus_i.out_addr), 64'h1024);
      chk("single_src",  64'(bus_i.out_src),  64'd1);

      // All four requesting continuously from rr_ptr=0.
      cycle(1, 0, 1, 0);
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_on[i]) set_req(i, 32'h100 * (c + 1), 32'(i), 6'(c * 4 + i));
         cycle(1, 0, 0, 0);
      end

      // Backpressure on address 0x2000 with other requests pending.
      cycle(1, 0, 1, 0);
      set_req(0, 32'h2000, 32'h0, 6'd9);
      cycle(1, 0, 0, 0);
      set_req(1, 32'h11, 32'h22, 6'd3);
      set_req(2, 32'h33, 32'h44, 6'd4);
      repeat (3) cycle(0, 0, 0, 0);
      chk("bp_addr", 64'(bus_i.out_addr), 64'h2000);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);

      // Squash while blocked, stale FU ready forced on the following cycle.
      set_req(3, 32'h500, 32'h5, 6'd7);
      cycle(1, 0, 0, 0);
      set_req(0, 32'h600, 32'h6, 6'd8);
      set_req(1, 32'h700, 32'h7, 6'd10);
      cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);

      // Wrap/fairness: move rr_ptr to 3, then 0 and 3 compete.
      cycle(1, 0, 1, 0);
      set_req(2, 32'h1, 32'h1, 6'd1);
      cycle(1, 0, 0, 0);
      set_req(0, 32'h10, 32'h0, 6'd20);
      set_req(3, 32'h30, 32'h0, 6'd23);
      cycle(1, 0, 0, 0);
      set_req(3, 32'h31, 32'h0, 6'd24);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);

      // Reset while blocked, then all four request.
      set_req(2, 32'h900, 32'h9, 6'd2);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
      for (int i = 0; i < N; i++) set_req(i, 32'h40 * i, 32'h4, 6'(i));
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_on[i] && $urandom_range(0, 1) == 1)
               set_req(i, $urandom, $urandom, 6'($urandom_range(0, 63)));
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
               $urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0);
      end
      for (int i = 0; i < N; i++) req_on[i] = 1'b0;
      repeat (3) cycle(1, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/agu_issue_arbiter.md
Name: agu_issue_arbiter

Overview:
- Round-robin scheduler that shares one single-cycle address-calculation FU between NUM_REQ load/store issue requesters.
- Selects at most one request per cycle and drives the FU's operands, rd_in and stall.
- Tracks the in-flight request's tag and source index in step with the FU output register.
- Presents the computed address downstream (LSQ) with a valid/ready handshake; supports squash (mispredict recovery).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
XLEN, 32, operand/address width
TAG_W, 6, destination/LSQ tag width carried alongside the operation

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
squash  in  1  kill all pending grants and the in-flight operation
req_valid  in  NUM_REQ  per-requester request
req_rs1  in  NUM_REQ*XLEN  base operand, requester i at bits [i*XLEN +: XLEN]
req_rs2  in  NUM_REQ*XLEN  offset operand, same packing
req_tag  in  NUM_REQ*TAG_W  tag, same packing
req_grant  out  NUM_REQ  one-hot; requester i accepted this cycle (combinational)
fu_rd_in  out  1  to FU: load new operands at next edge
fu_stall  out  1  to FU: hold output register
fu_rs1  out  XLEN  selected rs1 to FU
fu_rs2  out  XLEN  selected rs2 to FU
fu_data_ready  in  1  FU output register valid
fu_result  in  XLEN  FU output (rs1+rs2)
out_valid  out  1  address valid to consumer
out_addr  out  XLEN  = fu_result
out_tag  out  TAG_W  tag of in-flight op
out_src  out  clog2(NUM_REQ)  requester index of in-flight op
out_ready  in  1  consumer accepts

Behaviour:
- Reset (synchronous, active-high):
  - rr_ptr=0, pipe_valid=0, pipe_tag=0, pipe_src=0.
  - Outputs: req_grant=0, fu_rd_in=0, fu_stall=0, out_valid=0; fu_rs1/fu_rs2 driven 0 when no grant.
- Stall: fu_stall = out_valid & ~out_ready & ~squash.
- Grant enable: grant_en = ~fu_stall & ~squash & ~reset.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first i with req_valid[i] gets req_grant[i]=1 if grant_en.
  - At most one grant bit is set; none if no req_valid or ~grant_en.
- Operand select: fu_rd_in = |req_grant; fu_rs1/fu_rs2 = granted requester's operands, else 0.
- Pointer: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ (wraps NUM_REQ-1 -> 0). Unchanged with no grant.
- Pipeline tracking, priority order:
  - reset: clear.
  - squash: pipe_valid<=0.
  - fu_stall: hold pipe_valid/pipe_tag/pipe_src.
  - grant to i: pipe_valid<=1, pipe_tag<=req_tag[i], pipe_src<=i.
  - otherwise: pipe_valid<=0.
- Output: out_valid = fu_data_ready & pipe_valid. out_addr=fu_result, out_tag=pipe_tag, out_src=pipe_src.
- Latency: grant in cycle N -> out_valid in N+1. Holds each following cycle while out_ready=0.
- Throughput: one op per cycle when out_ready=1. Back-to-back grants allowed while out_valid&out_ready.
- Handshake: out_valid, once asserted, stays asserted with stable addr/tag/src until out_ready=1 or squash. A requester must hold req_valid until granted; the arbiter keeps no request state.
- Squash:
  - Same cycle: no grant and fu_stall=0, so the FU drains or clears.
  - Next cycle: out_valid=0 regardless of fu_data_ready. A stale FU result is never presented.
- Simultaneous out_ready=1 and new requests: the new grant is issued the same cycle (pipelined replace).
- State view for coverage:
  - IDLE (~pipe_valid)
  - ISSUE (pipe_valid & ~fu_stall)
  - BLOCKED (fu_stall)
  - BLOCKED->ISSUE/IDLE on out_ready or squash.
- Reset mid-BLOCKED: next cycle all outputs at reset values, rr_ptr=0.

Test Plan:
- Single request, NUM_REQ=4: req_valid=0010, rs1=0x1000, rs2=0x24, tag=5.
  - req_grant=0010 and fu_rd_in=1 same cycle.
  - Next cycle: out_valid=1, out_addr=0x1024, out_tag=5, out_src=1; rr_ptr=2.
- All four requesting continuously with out_ready=1 from rr_ptr=0: grants 0,1,2,3,0 on consecutive cycles; out_src follows one cycle later.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 (addr 0x2000).
  - fu_stall=1 and req_grant=0 throughout; out_addr/tag stable.
  - On out_ready=1, a new grant is issued the same cycle.
- Squash during BLOCKED with pending requests:
  - Squash cycle: no grant, fu_stall=0.
  - Next cycle: out_valid=0 even if fu_data_ready=1.
  - Following cycle: grants resume from the unchanged rr_ptr.
- Wrap/fairness: rr_ptr=3, req_valid=1001 -> grant 3, then grant 0, then grant 3 (no starvation).
- Synchronous reset asserted while out_valid=1, out_ready=0:
  - Next edge: out_valid=0, req_grant=0, rr_ptr=0.
  - First post-reset grant with req_valid=1111 goes to requester 0.
